// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding, unit indices, opcode constants and IR field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_WAIT,
        S_ADVANCE,
        S_HALT
    } seq_state_t;

    localparam logic [1:0] UNIT_ALU  = 2'd0;
    localparam logic [1:0] UNIT_LDST = 2'd1;
    localparam logic [1:0] UNIT_BR   = 2'd2;
    localparam logic [1:0] UNIT_MOVE = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int P1_MSB = 11;
    localparam int P1_LSB = 6;
    localparam int P2_MSB = 5;
    localparam int P2_LSB = 0;

    // One-hot unit select to binary index; input is guaranteed one-hot or zero.
    function automatic logic [1:0] unit_index(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode classifier.
//   opcode_i      : IR opcode field
//   is_nop_o      : opcode is NOP
//   is_halt_o     : opcode is HALT
//   unit_onehot_o : bit0 ALU (0001-0111), bit1 LDST (10xx), bit2 BRANCH (110x), bit3 MOVE (1110)
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_nop_o,
    output logic       is_halt_o,
    output logic [3:0] unit_onehot_o
);

    assign is_nop_o  = opcode_i == OP_NOP;
    assign is_halt_o = opcode_i == OP_HALT;
    assign unit_onehot_o = {
        opcode_i == 4'b1110,
        opcode_i[3:1] == 3'b110,
        opcode_i[3:2] == 2'b10,
        !opcode_i[3] && !is_nop_o
    };

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch sequencer that starts one execution unit at a time.
//   clk, reset        : clock, asynchronous active-high reset
//   run               : level enable, sampled in IDLE and ADVANCE
//   mem_rd/mem_rdata/mem_valid : program memory fetch at address pc
//   pc                : program counter, wraps modulo 2^PC_W
//   opCode/para1/para2: IR fields, stable from DECODE through ADVANCE
//   unit_start/unit_done : one-hot start pulse and per-unit done pulse
//   pc_load/pc_target : branch redirect, honoured only with unit_done[2]
//   busy/halted/fault : status; fault is sticky
// Build option SEQ_WATCHDOG_EN: WAIT longer than WDOG_CYCLES faults and halts.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int WDOG_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            mem_rd,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_valid,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      opCode,
    output logic [5:0]      para1,
    output logic [5:0]      para2,
    output logic [3:0]      unit_start,
    input  logic [3:0]      unit_done,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_target,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    seq_state_t      state_q, state_d;
    logic [15:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] br_tgt_q;
    logic            br_pend_q;
    logic [1:0]      idx_q;
    logic            mem_rd_q;
    logic            busy_q;
    logic            halted_q;
    logic [3:0]      unit_start_q;
    logic            is_nop;
    logic            is_halt;
    logic [3:0]      unit_oh;
    logic            done_sel;
    logic            wdog_trip;

    instr_decode u_decode (
        .opcode_i     (ir_q[OP_MSB:OP_LSB]),
        .is_nop_o     (is_nop),
        .is_halt_o    (is_halt),
        .unit_onehot_o(unit_oh)
    );

    // Only the dispatched unit's done counts; other done bits are ignored.
    assign done_sel = unit_done[idx_q];

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
    logic            fault_q;

    // Counter is zero on WAIT entry; trips in the WDOG_CYCLES-th WAIT cycle.
    assign wdog_trip = state_q == S_WAIT && !done_sel && wdog_q == WD_W'(WDOG_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= state_q == S_WAIT ? wdog_q + 1'b1 : '0;
            fault_q <= fault_q | wdog_trip;
        end
    end

    assign fault = fault_q;
`else
    assign wdog_trip = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:    state_d = mem_valid ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = is_halt ? S_HALT : is_nop ? S_ADVANCE : S_DISPATCH;
            S_DISPATCH: state_d = S_WAIT;
            S_WAIT:     state_d = done_sel ? S_ADVANCE : wdog_trip ? S_HALT : S_WAIT;
            S_ADVANCE:  state_d = run ? S_FETCH : S_IDLE;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            pc_q         <= '0;
            br_tgt_q     <= '0;
            br_pend_q    <= 1'b0;
            idx_q        <= '0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            unit_start_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_rd_q     <= state_d == S_FETCH;
            busy_q       <= !(state_d inside {S_IDLE, S_HALT});
            halted_q     <= state_d == S_HALT;
            // DISPATCH is only entered from DECODE, where unit_oh is valid.
            unit_start_q <= state_d == S_DISPATCH ? unit_oh : '0;
            if (state_q == S_FETCH && mem_valid)
                ir_q <= mem_rdata;
            if (state_q == S_DECODE)
                idx_q <= unit_index(unit_oh);
            if (state_q == S_WAIT && done_sel && idx_q == UNIT_BR && pc_load) begin
                br_pend_q <= 1'b1;
                br_tgt_q  <= pc_target;
            end
            if (state_q == S_ADVANCE) begin
                pc_q      <= br_pend_q ? br_tgt_q : pc_q + PC_W'(1);
                br_pend_q <= 1'b0;
            end
        end
    end

    assign mem_rd     = mem_rd_q;
    assign pc         = pc_q;
    assign opCode     = ir_q[OP_MSB:OP_LSB];
    assign para1      = ir_q[P1_MSB:P1_LSB];
    assign para2      = ir_q[P2_MSB:P2_LSB];
    assign unit_start = unit_start_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Top-level instruction sequencer for the bus-based CPU. Fetches a 16-bit instruction from program memory and latches it into an internal IR (opCode[15:12], para1[11:6], para2[5:0]). Decodes the opcode to one of four execution FSMs (ALU, load/store, branch, move), pulses that FSM's start, and waits for its done. Advances or loads the PC, then repeats. It is the only block that starts execution FSMs, so at most one FSM ever drives the shared bus and ALU.

Parameters:
PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
WDOG_CYCLES, 32, maximum WAIT cycles before fault (watchdog build only).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
run  in  1  level; enables fetching new instructions
mem_rd  out  1  program memory read request; address = pc
mem_rdata  in  16  instruction word
mem_valid  in  1  mem_rdata valid this cycle
pc  out  PC_W  current program counter
opCode  out  4  IR opcode field, to execution FSMs
para1  out  6  IR para1 field
para2  out  6  IR para2 field
unit_start  out  4  one-hot start pulse; bit0 ALU, bit1 LDST, bit2 BRANCH, bit3 MOVE
unit_done  in  4  per-unit done pulse
pc_load  in  1  branch taken; sampled only with unit_done[2]
pc_target  in  PC_W  branch target
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
fault  out  1  sticky fault flag

Behaviour:
- Reset values: pc=0, IR=0 (so opCode/para1/para2=0), mem_rd=0, unit_start=0, busy=0, halted=0, fault=0, state=IDLE. Reset mid-instruction aborts immediately; no start pulse is issued after reset.
- States: IDLE, FETCH, DECODE, DISPATCH, WAIT, ADVANCE, HALT. All outputs are registered or decoded from state only (Moore).
- IDLE: when run=1, go to FETCH. Otherwise stay.
- FETCH: mem_rd=1. On mem_valid=1, latch mem_rdata into IR and go to DECODE. Otherwise hold with no limit on wait.
- DECODE: classify opCode:
  - 0000 = NOP, go to ADVANCE.
  - 0001-0111 = ALU, unit 0.
  - 1000-1011 = LDST, unit 1.
  - 1100-1101 = BRANCH, unit 2.
  - 1110 = MOVE, unit 3.
  - 1111 = HALT, go to HALT.
  - For units 0-3, store the unit index and go to DISPATCH.
- DISPATCH: unit_start[idx]=1 for exactly one cycle, then go to WAIT.
- WAIT: watch only unit_done[idx]; done bits of other units are ignored. On done, go to ADVANCE. If idx=2 and pc_load=1 in the same cycle, latch pc_target into a pending-branch register.
- ADVANCE: pc <= pending branch ? pc_target : pc+1, wrapping from 2^PC_W-1 to 0. Clear the pending flag. Then go to FETCH if run=1, else IDLE.
- run dropping mid-instruction: the current instruction completes. run is sampled only in IDLE and ADVANCE.
- HALT: halted=1, pc is frozen at the HALT address. Exit only by reset.
- IR is stable from DECODE through ADVANCE; execution FSMs may read opCode/para1/para2 at any time while their start/done window is open.
- Latency: with mem_valid one cycle after mem_rd, a NOP takes 4 cycles (FETCH x2, DECODE, ADVANCE). An executing instruction takes 5 cycles plus its unit latency.

Optional Feature:
SEQ_WATCHDOG_EN
- Defined: a WAIT-cycle counter resets on entry to WAIT. If it reaches WDOG_CYCLES without unit_done[idx], set fault=1 and go to HALT.
- Undefined: no counter, WAIT holds indefinitely, and fault is tied to 0.

Decomposition:
- Shared package cpu_pkg: state encoding constants, unit index constants (UNIT_ALU=0, UNIT_LDST=1, UNIT_BR=2, UNIT_MOVE=3), opcode constants OP_NOP=4'b0000 and OP_HALT=4'b1111, IR field positions.
- One natural sub-module, instr_decode: purely combinational opCode to {is_nop, is_halt, unit_onehot}. Reused by the disassembly monitor in the bench.

Test Plan:
- Reset, run=1, program [0x0000 NOP, 0xF000 HALT], mem_valid 1 cycle after mem_rd -> pc steps 0→1; halted=1 at pc=1; unit_start never asserted.
- Instr 0x1042 (ADD, para1=1, para2=2) -> unit_start=0001 for one cycle, para1=1, para2=2; done after 9 cycles -> pc=1, next FETCH.
- Branch 0xC000 at pc=5, unit_done[2] with pc_load=1, pc_target=0x20 -> pc=0x20. Same with pc_load=0 -> pc=6.
- pc=0xFF, NOP -> pc wraps to 0x00. Spurious unit_done=1000 during an ALU WAIT -> ignored, FSM stays in WAIT.
- run dropped during WAIT -> instruction completes, pc increments, state IDLE, busy=0. run re-raised -> FETCH resumes at the new pc.
- SEQ_WATCHDOG_EN, WDOG_CYCLES=32, unit never signals done -> fault=1 and halted=1 after 32 WAIT cycles. Async reset pulse mid-WAIT -> all outputs reset, no start pulse.
